// File: rtl/next_pc_unit_if.sv
// rtl/next_pc_unit_if.sv - instruction/PC bus between decode, register file and next_pc_unit
//
// Carries one instruction and its operands into the next-PC unit, and the unit's PC and status back out.
//   master : drives inst_valid, inst, stall, rs1_data, rs2_data
//            observes pc, next_pc_sel, ras_pred, mispredict, misaligned, mispredict_cnt
//   slave  : the next_pc_unit side, with the opposite directions
interface next_pc_unit_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
);
   logic              inst_valid;
   logic [31:0]       inst;
   logic              stall;
   logic [XLEN-1:0]   rs1_data;
   logic [XLEN-1:0]   rs2_data;
   logic [XLEN-1:0]   pc;
   logic [2:0]        next_pc_sel;
   logic [XLEN-1:0]   ras_pred;
   logic              mispredict;
   logic              misaligned;
   logic [CNT_W-1:0]  mispredict_cnt;

   modport master (
      output inst_valid, inst, stall, rs1_data, rs2_data,
      input  pc, next_pc_sel, ras_pred, mispredict, misaligned, mispredict_cnt
   );

   modport slave (
      input  inst_valid, inst, stall, rs1_data, rs2_data,
      output pc, next_pc_sel, ras_pred, mispredict, misaligned, mispredict_cnt
   );
endinterface

// File: rtl/next_pc_unit.sv
// rtl/next_pc_unit.sv - RV32I next-PC generator with branch resolution and return-address stack
//
// Decodes JAL/JALR/conditional branches, computes the next PC, owns the PC register
// and a circular return-address stack that predicts JALR returns.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - next_pc_unit_if.slave:
//            inst_valid/inst/stall/rs1_data/rs2_data in,
//            pc (registered), next_pc_sel and ras_pred (combinational),
//            mispredict/misaligned (one-cycle pulses), mispredict_cnt (saturating) out
module next_pc_unit #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter int              RAS_DEPTH = 4,
   parameter int              CNT_W     = 16
) (
   input logic           clk,
   input logic           rst_n,
   next_pc_unit_if.slave bus
);

   localparam int PTR_W   = $clog2(RAS_DEPTH);
   localparam int RCNT_W  = $clog2(RAS_DEPTH + 1);

   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] SEL_SEQ    = 3'd0;
   localparam logic [2:0] SEL_JAL    = 3'd1;
   localparam logic [2:0] SEL_BRANCH = 3'd2;
   localparam logic [2:0] SEL_REG    = 3'd3;

   // architectural state
   logic [XLEN-1:0]   pc_q;
   logic [PTR_W-1:0]  ras_top;
   logic [RCNT_W-1:0] ras_cnt;
   logic [XLEN-1:0]   ras_mem [RAS_DEPTH];
   logic              mispredict_q;
   logic              misaligned_q;
   logic [CNT_W-1:0]  mispredict_cnt_q;

   // instruction fields
   logic [6:0]      opcode;
   logic [2:0]      f3;
   logic [4:0]      rd;
   logic [4:0]      rs1;
   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_b;
   logic [XLEN-1:0] imm_j;

   assign opcode = bus.inst[6:0];
   assign rd     = bus.inst[11:7];
   assign f3     = bus.inst[14:12];
   assign rs1    = bus.inst[19:15];

   assign imm_i = {{(XLEN-12){bus.inst[31]}}, bus.inst[31:20]};
   assign imm_b = {{(XLEN-13){bus.inst[31]}}, bus.inst[31], bus.inst[7],
                   bus.inst[30:25], bus.inst[11:8], 1'b0};
   assign imm_j = {{(XLEN-21){bus.inst[31]}}, bus.inst[31], bus.inst[19:12],
                   bus.inst[20], bus.inst[30:21], 1'b0};

   // decode
   logic is_jal;
   logic is_jalr;
   logic is_branch;
   logic br_taken;
   logic [2:0] sel;

   assign is_jal    = bus.inst_valid && (opcode == OP_JAL);
   assign is_jalr   = bus.inst_valid && (opcode == OP_JALR) && (f3 == 3'b000);
   assign is_branch = bus.inst_valid && (opcode == OP_BRANCH);

   always_comb begin
      br_taken = 1'b0;
      case (f3)
         3'b000:  br_taken = (bus.rs1_data == bus.rs2_data);
         3'b001:  br_taken = (bus.rs1_data != bus.rs2_data);
         3'b100:  br_taken = ($signed(bus.rs1_data) <  $signed(bus.rs2_data));
         3'b101:  br_taken = ($signed(bus.rs1_data) >= $signed(bus.rs2_data));
         3'b110:  br_taken = (bus.rs1_data <  bus.rs2_data);
         3'b111:  br_taken = (bus.rs1_data >= bus.rs2_data);
         default: br_taken = 1'b0;   // 010/011 are not branches
      endcase
   end

   always_comb begin
      sel = SEL_SEQ;
      if (is_jal)
         sel = SEL_JAL;
      else if (is_jalr)
         sel = SEL_REG;
      else if (is_branch && br_taken)
         sel = SEL_BRANCH;
   end

   // targets
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] jalr_sum;
   logic [XLEN-1:0] target;

   assign pc_plus4 = pc_q + XLEN'(4);
   assign jalr_sum = bus.rs1_data + imm_i;

   always_comb begin
      target = pc_plus4;
      case (sel)
         SEL_JAL:    target = pc_q + imm_j;
         SEL_BRANCH: target = pc_q + imm_b;
         SEL_REG:    target = {jalr_sum[XLEN-1:1], 1'b0};
         default:    target = pc_plus4;
      endcase
   end

   logic update;
   logic misalign_now;
   logic aligned_upd;

   assign update       = bus.inst_valid && !bus.stall;
   assign misalign_now = (sel != SEL_SEQ) && target[1];
   assign aligned_upd  = update && !misalign_now;

   // RAS push/pop classification from the link-register hints
   logic rd_link;
   logic rs1_link;
   logic do_push;
   logic do_pop;

   assign rd_link  = (rd  == 5'd1) || (rd  == 5'd5);
   assign rs1_link = (rs1 == 5'd1) || (rs1 == 5'd5);

   always_comb begin
      do_push = 1'b0;
      do_pop  = 1'b0;
      if (is_jal) begin
         do_push = rd_link;
      end else if (is_jalr) begin
         case ({rd_link, rs1_link})
            2'b01: do_pop  = 1'b1;
            2'b10: do_push = 1'b1;
            2'b11: begin
               do_push = 1'b1;
               do_pop  = (rd != rs1);   // same link reg on both sides is a call, not a coroutine swap
            end
            default: ;
         endcase
      end
   end

   logic [XLEN-1:0] ras_top_val;
   assign ras_top_val = (ras_cnt == '0) ? '0 : ras_mem[ras_top];

   // next RAS state
   logic [PTR_W-1:0]  top_n;
   logic [RCNT_W-1:0] cnt_n;
   logic              wr_en;
   logic [PTR_W-1:0]  wr_idx;

   always_comb begin
      top_n  = ras_top;
      cnt_n  = ras_cnt;
      wr_en  = 1'b0;
      wr_idx = ras_top;
      if (aligned_upd) begin
         if (do_pop && do_push && (ras_cnt != '0)) begin
            // pop-then-push collapses to overwriting the current top
            wr_en  = 1'b1;
            wr_idx = ras_top;
         end else if (do_push) begin
            // also covers pop-then-push on an empty stack (the pop is a no-op)
            top_n  = ras_top + PTR_W'(1);
            wr_idx = ras_top + PTR_W'(1);
            wr_en  = 1'b1;
            if (ras_cnt != RCNT_W'(RAS_DEPTH))
               cnt_n = ras_cnt + RCNT_W'(1);
         end else if (do_pop && (ras_cnt != '0)) begin
            top_n = ras_top - PTR_W'(1);
            cnt_n = ras_cnt - RCNT_W'(1);
         end
      end
   end

   // a popping return is wrong if the stack was empty or the prediction missed
   logic misp_now;
   assign misp_now = aligned_upd && do_pop &&
                     ((ras_cnt == '0) || (target != ras_top_val));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q             <= RESET_PC;
         ras_top          <= '0;
         ras_cnt          <= '0;
         mispredict_q     <= 1'b0;
         misaligned_q     <= 1'b0;
         mispredict_cnt_q <= '0;
      end else begin
         mispredict_q <= misp_now;
         misaligned_q <= update && misalign_now;
         ras_top      <= top_n;
         ras_cnt      <= cnt_n;
         if (aligned_upd)
            pc_q <= target;
         if (misp_now && (mispredict_cnt_q != '1))
            mispredict_cnt_q <= mispredict_cnt_q + CNT_W'(1);
      end
   end

   // entry contents are don't-care after reset, so no reset branch
   always_ff @(posedge clk) begin
      if (wr_en)
         ras_mem[wr_idx] <= pc_plus4;
   end

   assign bus.pc             = pc_q;
   assign bus.next_pc_sel    = sel;
   assign bus.ras_pred       = ras_top_val;
   assign bus.mispredict     = mispredict_q;
   assign bus.misaligned     = misaligned_q;
   assign bus.mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// tb/tb_next_pc_unit.sv - scoreboard bench for next_pc_unit with directed vectors
module tb_next_pc_unit;

   logic clk;
   logic rst_n;

   next_pc_unit_if #(.XLEN(32), .CNT_W(16)) bus ();

   next_pc_unit #(
      .XLEN(32), .RESET_PC(32'h0), .RAS_DEPTH(4), .CNT_W(16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      string       name;
      logic [2:0]  sel;
      logic [31:0] ras;
   } comb_t;

   typedef struct {
      string       name;
      logic [31:0] pc;
      logic        misp;
      logic        misal;
      logic [15:0] cnt;
   } reg_t;

   comb_t comb_q[$];
   reg_t  reg_q[$];
   int    checks   = 0;
   int    failures = 0;
   logic  prev_valid;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%h expected=0x%h", n, act, exp);
      end
   endtask

   function automatic logic [31:0] enc_jal(input int rd, input int imm);
      logic [31:0] m;
      m = imm;
      return {m[20], m[10:1], m[11], m[19:12], 5'(rd), 7'b1101111};
   endfunction

   function automatic logic [31:0] enc_jalr(input int f3, input int rd, input int rs1, input int imm);
      logic [31:0] m;
      m = imm;
      return {m[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'b1100111};
   endfunction

   function automatic logic [31:0] enc_br(input int f3, input int imm);
      logic [31:0] m;
      m = imm;
      return {m[12], m[10:5], 5'd2, 5'd1, 3'(f3), m[4:1], m[11], 7'b1100011};
   endfunction

   localparam logic [31:0] ADDI = 32'h0000_0013;

   // present one instruction for one cycle and queue its expected responses
   task automatic issue(input string n, input logic [31:0] i, input logic [31:0] a,
                        input logic [31:0] b, input logic st,
                        input logic [2:0] esel, input logic [31:0] eras,
                        input logic [31:0] epc, input logic emisp, input logic emisal,
                        input logic [15:0] ecnt);
      comb_t c;
      reg_t  r;
      @(posedge clk);
      #1;
      bus.inst_valid = 1'b1;
      bus.inst       = i;
      bus.rs1_data   = a;
      bus.rs2_data   = b;
      bus.stall      = st;
      c.name = n; c.sel = esel; c.ras = eras;
      r.name = n; r.pc = epc; r.misp = emisp; r.misal = emisal; r.cnt = ecnt;
      comb_q.push_back(c);
      reg_q.push_back(r);
   endtask

   task automatic go_idle();
      @(posedge clk);
      #1;
      bus.inst_valid = 1'b0;
      bus.stall      = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   // monitor: combinational outputs belong to the instruction on the bus now,
   // registered outputs to the instruction presented one cycle earlier
   initial begin
      comb_t c;
      reg_t  r;
      prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (prev_valid) begin
            if (reg_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL reg_q_underflow actual=empty expected=entry");
            end else begin
               r = reg_q.pop_front();
               chk({r.name, "_pc"},    bus.pc,                     r.pc);
               chk({r.name, "_misp"},  {31'd0, bus.mispredict},    {31'd0, r.misp});
               chk({r.name, "_misal"}, {31'd0, bus.misaligned},    {31'd0, r.misal});
               chk({r.name, "_cnt"},   {16'd0, bus.mispredict_cnt}, {16'd0, r.cnt});
            end
         end
         if (bus.inst_valid === 1'b1) begin
            if (comb_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL comb_q_underflow actual=empty expected=entry");
            end else begin
               c = comb_q.pop_front();
               chk({c.name, "_sel"}, {29'd0, bus.next_pc_sel}, {29'd0, c.sel});
               chk({c.name, "_ras"}, bus.ras_pred,              c.ras);
            end
         end
         prev_valid = (bus.inst_valid === 1'b1);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n          = 1'b0;
      bus.inst_valid = 1'b0;
      bus.inst       = 32'h0;
      bus.stall      = 1'b0;
      bus.rs1_data   = 32'h0;
      bus.rs2_data   = 32'h0;
      #3;
      chk("reset_pc",   bus.pc,                      32'h0);
      chk("reset_sel",  {29'd0, bus.next_pc_sel},    32'h0);
      chk("reset_ras",  bus.ras_pred,                32'h0);
      chk("reset_misp", {31'd0, bus.mispredict},     32'h0);
      chk("reset_mal",  {31'd0, bus.misaligned},     32'h0);
      chk("reset_cnt",  {16'd0, bus.mispredict_cnt}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // sequential flow
      issue("addi0", ADDI, 0, 0, 0, 3'd0, 32'h0, 32'h4, 0, 0, 16'd0);
      issue("addi1", ADDI, 0, 0, 0, 3'd0, 32'h0, 32'h8, 0, 0, 16'd0);
      issue("addi2", ADDI, 0, 0, 0, 3'd0, 32'h0, 32'hC, 0, 0, 16'd0);
      issue("j100",  enc_jal(0, 32'hF4), 0, 0, 0, 3'd1, 32'h0, 32'h100, 0, 0, 16'd0);

      // branches at 0x100 / 0x200
      issue("beq",   enc_br(0, 32'h20), 5, 5, 0, 3'd2, 32'h0, 32'h120, 0, 0, 16'd0);
      issue("jback", enc_jal(0, -32'sh20), 0, 0, 0, 3'd1, 32'h0, 32'h100, 0, 0, 16'd0);
      issue("bne",   enc_br(1, 32'h20), 5, 5, 0, 3'd0, 32'h0, 32'h104, 0, 0, 16'd0);
      issue("j200",  enc_jal(0, 32'hFC), 0, 0, 0, 3'd1, 32'h0, 32'h200, 0, 0, 16'd0);
      issue("blt",   enc_br(4, -8), 32'hFFFF_FFFF, 1, 0, 3'd2, 32'h0, 32'h1F8, 0, 0, 16'd0);
      issue("j200b", enc_jal(0, 8), 0, 0, 0, 3'd1, 32'h0, 32'h200, 0, 0, 16'd0);
      issue("bltu",  enc_br(6, -8), 32'hFFFF_FFFF, 1, 0, 3'd0, 32'h0, 32'h204, 0, 0, 16'd0);

      // call / return
      issue("j40",   enc_jal(0, -32'sh1C4), 0, 0, 0, 3'd1, 32'h0, 32'h40, 0, 0, 16'd0);
      issue("call1", enc_jal(1, 32'h100), 0, 0, 0, 3'd1, 32'h0, 32'h140, 0, 0, 16'd0);
      issue("ret1",  enc_jalr(0, 0, 1, 0), 32'h44, 0, 0, 3'd3, 32'h44, 32'h44, 0, 0, 16'd0);
      issue("j40b",  enc_jal(0, -4), 0, 0, 0, 3'd1, 32'h0, 32'h40, 0, 0, 16'd0);
      issue("call2", enc_jal(1, 32'h100), 0, 0, 0, 3'd1, 32'h0, 32'h140, 0, 0, 16'd0);
      issue("ret2",  enc_jalr(0, 0, 1, 0), 32'h48, 0, 0, 3'd3, 32'h44, 32'h48, 1, 0, 16'd1);
      issue("j0",    enc_jal(0, -32'sh48), 0, 0, 0, 3'd1, 32'h0, 32'h0, 0, 0, 16'd1);

      // RAS overflow: five nested calls into a four-entry stack
      issue("nc0", enc_jal(1, 32'h100), 0, 0, 0, 3'd1, 32'h0,   32'h100, 0, 0, 16'd1);
      issue("nc1", enc_jal(1, 32'h100), 0, 0, 0, 3'd1, 32'h4,   32'h200, 0, 0, 16'd1);
      issue("nc2", enc_jal(1, 32'h100), 0, 0, 0, 3'd1, 32'h104, 32'h300, 0, 0, 16'd1);
      issue("nc3", enc_jal(1, 32'h100), 0, 0, 0, 3'd1, 32'h204, 32'h400, 0, 0, 16'd1);
      issue("nc4", enc_jal(1, 32'h100), 0, 0, 0, 3'd1, 32'h304, 32'h500, 0, 0, 16'd1);
      issue("nr0", enc_jalr(0, 0, 1, 0), 32'h404, 0, 0, 3'd3, 32'h404, 32'h404, 0, 0, 16'd1);
      issue("nr1", enc_jalr(0, 0, 1, 0), 32'h304, 0, 0, 3'd3, 32'h304, 32'h304, 0, 0, 16'd1);
      issue("nr2", enc_jalr(0, 0, 1, 0), 32'h204, 0, 0, 3'd3, 32'h204, 32'h204, 0, 0, 16'd1);
      issue("nr3", enc_jalr(0, 0, 1, 0), 32'h104, 0, 0, 3'd3, 32'h104, 32'h104, 0, 0, 16'd1);
      issue("nr4", enc_jalr(0, 0, 1, 0), 32'h4,   0, 0, 3'd3, 32'h0,   32'h4,   1, 0, 16'd2);

      // misaligned JALR leaves pc and RAS alone; stall suppresses a JAL
      issue("call3", enc_jal(1, 32'hC), 0, 0, 0, 3'd1, 32'h0, 32'h10, 0, 0, 16'd2);
      issue("misal", enc_jalr(0, 0, 1, 0), 32'h102, 0, 0, 3'd3, 32'h8, 32'h10, 0, 1, 16'd2);
      issue("stall", enc_jal(1, 32'h100), 0, 0, 1, 3'd1, 32'h8, 32'h10, 0, 0, 16'd2);
      issue("addi3", ADDI, 0, 0, 0, 3'd0, 32'h8, 32'h14, 0, 0, 16'd2);

      // non-jump encodings and bit-0 clearing
      issue("bf3_2",  enc_br(2, 32'h20), 5, 5, 0, 3'd0, 32'h8, 32'h18, 0, 0, 16'd2);
      issue("jalrf3", enc_jalr(1, 0, 1, 0), 32'h40, 0, 0, 3'd0, 32'h8, 32'h1C, 0, 0, 16'd2);
      issue("jalrb0", enc_jalr(0, 0, 2, 1), 32'h40, 0, 0, 3'd3, 32'h8, 32'h40, 0, 0, 16'd2);

      // pop-then-push replaces the top, then the new top is returned to
      issue("swap", enc_jalr(0, 5, 1, 0), 32'h8, 0, 0, 3'd3, 32'h8, 32'h8, 0, 0, 16'd2);
      issue("ret5", enc_jalr(0, 0, 1, 0), 32'h44, 0, 0, 3'd3, 32'h44, 32'h44, 0, 0, 16'd2);
      issue("addi4", ADDI, 0, 0, 0, 3'd0, 32'h0, 32'h48, 0, 0, 16'd2);

      go_idle();
      chk("drain_reg",  reg_q.size(),  0);
      chk("drain_comb", comb_q.size(), 0);

      // asynchronous reset in mid-cycle
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("areset_pc",  bus.pc,                      32'h0);
      chk("areset_cnt", {16'd0, bus.mispredict_cnt}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      issue("post_rst", ADDI, 0, 0, 0, 3'd0, 32'h0, 32'h4, 0, 0, 16'd0);
      go_idle();
      chk("final_drain", reg_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/next_pc_unit.md
# next_pc_unit

Parametrised next-PC generator for the RV32I fetch path. It decodes the jump and branch encodings JAL, JALR, BEQ, BNE, BLT, BGE, BLTU and BGEU, and resolves branch conditions from register operands. It owns the architectural PC register and a return-address stack (RAS) that predicts JALR returns. It sits between the instruction register and the fetch stage, and drives the PC plus a registered mispredict/misalign status.

## Interface
Parameters:
- XLEN, 32, datapath and PC width (32 or 64)
- RESET_PC, 0, PC value loaded on reset
- RAS_DEPTH, 4, number of RAS entries (power of two, 2..16)
- CNT_W, 16, width of the saturating mispredict counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- inst_valid  input  1  inst holds a valid instruction this cycle
- inst  input  32  instruction encoding
- stall  input  1  hold PC and RAS; no state update
- rs1_data  input  XLEN  register-file read of rs1
- rs2_data  input  XLEN  register-file read of rs2
- pc  output  XLEN  current PC (registered)
- next_pc_sel  output  3  0 = PC+4, 1 = PC+JAL imm, 2 = PC+branch imm, 3 = from RF (combinational)
- ras_pred  output  XLEN  RAS top-of-stack prediction, 0 when empty (combinational)
- mispredict  output  1  one-cycle pulse: a return's actual target differed from ras_pred
- misaligned  output  1  one-cycle pulse: taken target had bit 1 set
- mispredict_cnt  output  CNT_W  saturating count of mispredicts

## Operation
- An update occurs when inst_valid=1 and stall=0. With no update, pc, RAS and mispredict_cnt hold, and the pulses deassert.
- Decode (opcode/funct3):
  - JAL 1101111 gives sel 1.
  - JALR 1100111 with f3=000 gives sel 3.
  - BRANCH 1100011 with f3 in {000,001,100,101,110,111} gives sel 2 if the condition holds, else 0.
  - Everything else, including invalid branch f3 (010, 011), gives sel 0.
  - With inst_valid=0, sel is 0.
- Branch conditions: eq, ne, signed lt/ge, unsigned ltu/geu on the full XLEN operands.
- Immediates are sign-extended to XLEN. The J-imm and B-imm have bit 0 = 0.
- Targets:
  - sel 0: pc+4
  - sel 1: pc+J-imm
  - sel 2: pc+B-imm
  - sel 3: (rs1_data+I-imm) with bit 0 cleared
- All adds wrap modulo 2^XLEN.
- Misalignment: if sel is not 0 and target[1]=1, pc holds, misaligned pulses on the next cycle, and the RAS is not modified.
- Link register: rd or rs1 equal to x1 or x5.
- RAS actions (aligned updates only):
  - JAL with rd=link: push pc+4.
  - JALR with rd≠link and rs1=link: pop.
  - JALR with rd=link and rs1≠link: push.
  - JALR with rd=link, rs1=link, rd≠rs1: pop then push. The top is replaced and the count is unchanged.
  - JALR with rd=link and rd==rs1: push.
- RAS storage: a circular buffer with a top pointer and a count (0..RAS_DEPTH).
  - Push when full overwrites the oldest entry; count stays at RAS_DEPTH.
  - Pop when empty is a no-op.
- Return check: on any JALR update that pops, compare the actual target to ras_pred as it was before the pop.
  - On a mismatch, or a pop from an empty RAS, mispredict pulses on the next cycle.
  - mispredict_cnt increments on the same edge, saturating at all-ones.
- The PC always takes the actual target; the prediction is informational only.

## Timing
- Reset is asynchronous: on rst_n low, immediately pc=RESET_PC, RAS count=0, top=0, mispredict=0, misaligned=0, mispredict_cnt=0. RAS entry contents are don't-care.
- next_pc_sel and ras_pred are combinational from the current inputs and state, with zero latency.
- pc, RAS, the pulses and the counter update on the rising clk edge following the update cycle, so the latency from instruction to new pc is 1 cycle.
- Back-to-back updates every cycle are supported. There is no internal stall.
- A stall asserted together with inst_valid suppresses the update completely; the instruction is re-presented later.
- rst_n asserted mid-sequence discards pending state. The first post-reset update uses pc=RESET_PC.

## Test plan
- Reset, then 3 non-branch instructions (ADDI 0x00000013): pc goes 0 → 4 → 8 → 0xC; sel=0; all pulses stay 0.
- Branches at pc=0x100 with B-imm=+0x20 (rs1=5, rs2=5):
  - BEQ: sel=2, pc→0x120.
  - BNE: sel=0, pc→0x104.
- BLT with rs1=0xFFFFFFFF, rs2=1 at pc=0x200, B-imm −8: taken, pc→0x1F8. The same operands with BLTU: not taken, pc→0x204.
- Call/return: JAL x1 at pc=0x40 (imm +0x100) → pc=0x140, ras_pred=0x44. Then JALR x0,0(x1) with rs1_data=0x44 → pc=0x44, mispredict=0, RAS empty. Repeat with rs1_data=0x48 → mispredict=1, mispredict_cnt=1.
- RAS overflow (RAS_DEPTH=4): 5 nested JAL x1 calls from pc 0x0, 0x100, 0x200, 0x300, 0x400. The 5 returns predict 0x404, 0x304, 0x204, 0x104, then 0 on empty. The last return flags mispredict.
- Misaligned JALR target (rs1_data=0x102, imm 0) at pc=0x10: sel=3; next cycle misaligned=1, pc stays 0x10, RAS unchanged. Stall=1 with a valid JAL: pc and RAS unchanged.
